keypad_scan_module: RTL and testbench

- Scans a 4x4 active-low matrix keypad and returns debounced key events to the core.
- Input-side counterpart of the multiplexed 7-segment output path:
  - drives a one-hot-low column strobe (analogous to seg_control);
  - reads back the row lines.
- Its key_code/key_valid outputs feed the same top level that drives the BCD display.

---
 rtl/keypad_pkg.sv | 32 +++
 rtl/sync_2ff.sv | 28 ++
 rtl/keypad_scan_module.sv | 188 ++++++++++++++++++
 tb/tb_keypad_scan_module.sv | 266 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/keypad_pkg.sv
// Shared definitions for the 4x4 keypad scanner: FSM encoding, matrix size
// and the row priority encoder.
package keypad_pkg;

    localparam int KP_ROWS = 4;
    localparam int KP_COLS = 4;

    typedef enum logic [1:0] {
        SCAN     = 2'd0,
        DEBOUNCE = 2'd1,
        HELD     = 2'd2,
        RELEASE  = 2'd3
    } kp_state_e;

    // Any row pulled low means a key on the strobed column is closed.
    function automatic logic row_hit(input logic [KP_ROWS-1:0] rows);
        return ~&rows;
    endfunction

    // Lowest-index low row wins, so scan from the top down and keep overwriting.
    function automatic logic [1:0] row_encode(input logic [KP_ROWS-1:0] rows);
        logic [1:0] idx;
        idx = 2'd0;
        for (int i = KP_ROWS - 1; i >= 0; i--) begin
            if (!rows[i]) begin
                idx = 2'(i);
            end
        end
        return idx;
    endfunction

endpackage

// File: rtl/sync_2ff.sv
// Generic two-flop synchronizer for asynchronous board inputs.
module sync_2ff #(
    parameter int               WIDTH     = 1,
    parameter logic [WIDTH-1:0] RESET_VAL = {WIDTH{1'b1}}
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] meta_r;
    logic [WIDTH-1:0] sync_r;

    // Two-stage capture of the asynchronous input.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta_r <= RESET_VAL;
            sync_r <= RESET_VAL;
        end else begin
            meta_r <= d;
            sync_r <= meta_r;
        end
    end

    assign q = sync_r;

endmodule

// File: rtl/keypad_scan_module.sv
// 4x4 active-low keypad scanner: column strobe, synchronized row sampling,
// press/release debounce and one-cycle key events.
module keypad_scan_module
    import keypad_pkg::*;
#(
    parameter int SCAN_DIV     = 1000,  // >= 4 so the synchronizer settles within a slot
    parameter int DEBOUNCE_CNT = 8      // >= 1
) (
    input  logic                 sys_clk_in,
    input  logic                 reset,
    input  logic [KP_ROWS-1:0]   row_in,
    output logic [KP_COLS-1:0]   col_out,
    output logic [3:0]           key_code,
    output logic                 key_valid,
    output logic                 key_pressed
);

    localparam int PW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int CW = $clog2(DEBOUNCE_CNT + 1);

    logic [KP_ROWS-1:0] row_s;
    logic               tick_s;
    logic               hit_s;
    logic [1:0]         row_idx_s;

    logic [PW-1:0]      presc_r;
    kp_state_e          state_r,    state_nx;
    logic [CW-1:0]      count_r,    count_nx;
    logic [1:0]         col_r,      col_nx;
    logic [1:0]         cand_row_r, cand_row_nx;
    logic [1:0]         cand_col_r, cand_col_nx;
    logic               accept_s;
    logic               release_done_s;

    logic [KP_COLS-1:0] col_out_r;
    logic [3:0]         key_code_r;
    logic               key_valid_r;
    logic               key_pressed_r;

    sync_2ff #(
        .WIDTH     (KP_ROWS),
        .RESET_VAL ({KP_ROWS{1'b1}})
    ) u_row_sync (
        .clk   (sys_clk_in),
        .rst_n (reset),
        .d     (row_in),
        .q     (row_s)
    );

    assign tick_s    = (presc_r == PW'(SCAN_DIV - 1));
    assign hit_s     = row_hit(row_s);
    assign row_idx_s = row_encode(row_s);

    // Column slot prescaler; rows are only looked at on the last cycle of a slot.
    always_ff @(posedge sys_clk_in or negedge reset) begin
        if (!reset) begin
            presc_r <= PW'(0);
        end else if (tick_s) begin
            presc_r <= PW'(0);
        end else begin
            presc_r <= presc_r + PW'(1);
        end
    end

    // Scan/debounce state register.
    always_ff @(posedge sys_clk_in or negedge reset) begin
        if (!reset) begin
            state_r    <= SCAN;
            count_r    <= CW'(0);
            col_r      <= 2'd0;
            cand_row_r <= 2'd0;
            cand_col_r <= 2'd0;
        end else begin
            state_r    <= state_nx;
            count_r    <= count_nx;
            col_r      <= col_nx;
            cand_row_r <= cand_row_nx;
            cand_col_r <= cand_col_nx;
        end
    end

    // Next-state logic; nothing moves between ticks.
    always_comb begin
        state_nx       = state_r;
        count_nx       = count_r;
        col_nx         = col_r;
        cand_row_nx    = cand_row_r;
        cand_col_nx    = cand_col_r;
        accept_s       = 1'b0;
        release_done_s = 1'b0;
        if (tick_s) begin
            case (state_r)
                SCAN: begin
                    if (hit_s) begin
                        cand_row_nx = row_idx_s;
                        cand_col_nx = col_r;
                        if (DEBOUNCE_CNT == 1) begin
                            accept_s = 1'b1;
                            count_nx = CW'(0);
                            state_nx = HELD;
                        end else begin
                            count_nx = CW'(1);
                            state_nx = DEBOUNCE;
                        end
                    end else begin
                        col_nx = col_r + 2'd1;
                    end
                end
                DEBOUNCE: begin
                    if (hit_s && (row_idx_s == cand_row_r)) begin
                        if (count_r == CW'(DEBOUNCE_CNT - 1)) begin
                            accept_s = 1'b1;
                            count_nx = CW'(0);
                            state_nx = HELD;
                        end else begin
                            count_nx = count_r + CW'(1);
                        end
                    end else begin
                        count_nx = CW'(0);
                        col_nx   = col_r + 2'd1;
                        state_nx = SCAN;
                    end
                end
                HELD: begin
                    if (!hit_s) begin
                        if (DEBOUNCE_CNT == 1) begin
                            release_done_s = 1'b1;
                            count_nx       = CW'(0);
                            state_nx       = SCAN;
                        end else begin
                            count_nx = CW'(1);
                            state_nx = RELEASE;
                        end
                    end else begin
                        state_nx = HELD;
                    end
                end
                RELEASE: begin
                    // Column stays frozen here; it only advances on the next SCAN tick.
                    if (!hit_s) begin
                        if (count_r == CW'(DEBOUNCE_CNT - 1)) begin
                            release_done_s = 1'b1;
                            count_nx       = CW'(0);
                            state_nx       = SCAN;
                        end else begin
                            count_nx = count_r + CW'(1);
                        end
                    end else begin
                        state_nx = HELD;
                    end
                end
                default: begin
                    count_nx = CW'(0);
                    state_nx = SCAN;
                end
            endcase
        end else begin
            state_nx = state_r;
        end
    end

    // Registered column strobe and key outputs.
    always_ff @(posedge sys_clk_in or negedge reset) begin
        if (!reset) begin
            col_out_r     <= 4'b1110;
            key_code_r    <= 4'd0;
            key_valid_r   <= 1'b0;
            key_pressed_r <= 1'b0;
        end else begin
            col_out_r   <= ~(4'b0001 << col_nx);
            key_valid_r <= accept_s;
            if (accept_s) begin
                key_code_r    <= {cand_row_nx, cand_col_nx};
                key_pressed_r <= 1'b1;
            end else if (release_done_s) begin
                key_pressed_r <= 1'b0;
            end else begin
                key_pressed_r <= key_pressed_r;
            end
        end
    end

    assign col_out     = col_out_r;
    assign key_code    = key_code_r;
    assign key_valid   = key_valid_r;
    assign key_pressed = key_pressed_r;

endmodule

// File: tb/tb_keypad_scan_module.sv
// Directed bench for keypad_scan_module with a physical keypad model
// (closed-switch mask) driving the rows from the column strobe.
module tb_keypad_scan_module;

    logic        clk;
    logic        reset;
    logic [3:0]  row_in;
    logic [3:0]  col_out;
    logic [3:0]  key_code;
    logic        key_valid;
    logic        key_pressed;

    logic [15:0] mask;        // bit (row*4+col) set = switch closed
    int          cyc;         // posedges since reset release
    int          n_cmp;
    int          n_fail;
    int          valid_cnt;

    keypad_scan_module #(.SCAN_DIV(4), .DEBOUNCE_CNT(3)) dut (
        .sys_clk_in  (clk),
        .reset       (reset),
        .row_in      (row_in),
        .col_out     (col_out),
        .key_code    (key_code),
        .key_valid   (key_valid),
        .key_pressed (key_pressed)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // A closed switch pulls its row low while its column is strobed low.
    always_comb begin
        row_in = 4'b1111;
        for (int r = 0; r < 4; r++) begin
            row_in[r] = ~|(mask[r*4 +: 4] & ~col_out);
        end
    end

    always @(posedge clk) begin
        if (key_valid) valid_cnt <= valid_cnt + 1;
    end

    task automatic adv(input int n);
        repeat (n) begin
            @(negedge clk);
            cyc = cyc + 1;
        end
    endtask

    task automatic do_reset();
        reset = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b1;
        cyc = 0;
    endtask

    task automatic test_reset();
        logic [3:0] one;
        logic [3:0] exp_col;
        int v0;
        one = 4'b0001;
        mask = 16'h0000;
        reset = 1'b0;
        @(negedge clk);
        n_cmp++;
        if (col_out !== 4'b1110 || key_code !== 4'd0 || key_valid !== 1'b0 || key_pressed !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_vals: got col=%b code=%0d valid=%b pressed=%b expected col=1110 code=0 valid=0 pressed=0",
                     col_out, key_code, key_valid, key_pressed);
        end
        do_reset();
        v0 = valid_cnt;
        for (int k = 1; k <= 20; k++) begin
            adv(1);
            exp_col = ~(one << ((cyc / 4) % 4));
            n_cmp++;
            if (col_out !== exp_col) begin
                n_fail++;
                $display("FAIL scan_col cyc%0d: got %b expected %b", cyc, col_out, exp_col);
            end
        end
        n_cmp++;
        if (valid_cnt - v0 !== 0) begin
            n_fail++;
            $display("FAIL scan_no_valid: got %0d pulses expected 0", valid_cnt - v0);
        end
    endtask

    // Key 9 held, then released with one bounce-low sample in RELEASE.
    task automatic test_hold_release();
        int v0;
        mask = 16'h0000;
        mask[9] = 1'b1;
        do_reset();
        v0 = valid_cnt;
        adv(15);
        n_cmp++;
        if (key_valid !== 1'b0 || key_pressed !== 1'b0) begin
            n_fail++;
            $display("FAIL hold_early: got valid=%b pressed=%b expected 0 0", key_valid, key_pressed);
        end
        adv(1);
        n_cmp++;
        if (key_valid !== 1'b1 || key_code !== 4'd9 || key_pressed !== 1'b1 || col_out !== 4'b1101) begin
            n_fail++;
            $display("FAIL hold_accept: got valid=%b code=%0d pressed=%b col=%b expected 1 9 1 1101",
                     key_valid, key_code, key_pressed, col_out);
        end
        adv(1);
        n_cmp++;
        if (key_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL hold_pulse_width: got valid=%b expected 0", key_valid);
        end
        adv(40);
        n_cmp++;
        if (valid_cnt - v0 !== 1 || col_out !== 4'b1101 || key_pressed !== 1'b1) begin
            n_fail++;
            $display("FAIL hold_steady: got pulses=%0d col=%b pressed=%b expected 1 1101 1",
                     valid_cnt - v0, col_out, key_pressed);
        end
        adv(60 - cyc);
        mask[9] = 1'b0;
        adv(4);
        mask[9] = 1'b1;
        adv(4);
        mask[9] = 1'b0;
        n_cmp++;
        if (key_pressed !== 1'b1) begin
            n_fail++;
            $display("FAIL release_bounce: got pressed=%b expected 1", key_pressed);
        end
        adv(11);
        n_cmp++;
        if (key_pressed !== 1'b1 || col_out !== 4'b1101) begin
            n_fail++;
            $display("FAIL release_early: got pressed=%b col=%b expected 1 1101", key_pressed, col_out);
        end
        adv(1);
        n_cmp++;
        if (key_pressed !== 1'b0 || key_code !== 4'd9 || col_out !== 4'b1101) begin
            n_fail++;
            $display("FAIL release_done: got pressed=%b code=%0d col=%b expected 0 9 1101",
                     key_pressed, key_code, col_out);
        end
        adv(4);
        n_cmp++;
        if (col_out !== 4'b1011 || valid_cnt - v0 !== 1) begin
            n_fail++;
            $display("FAIL release_rescan: got col=%b pulses=%0d expected 1011 1", col_out, valid_cnt - v0);
        end
    endtask

    // Low one sample, high one sample, then stable low.
    task automatic test_bounce();
        int v0;
        mask = 16'h0000;
        do_reset();
        v0 = valid_cnt;
        adv(4);
        mask[9] = 1'b1;
        adv(4);
        mask[9] = 1'b0;
        adv(4);
        n_cmp++;
        if (col_out !== 4'b1011 || valid_cnt - v0 !== 0) begin
            n_fail++;
            $display("FAIL bounce_abort: got col=%b pulses=%0d expected 1011 0", col_out, valid_cnt - v0);
        end
        mask[9] = 1'b1;
        adv(23);
        n_cmp++;
        if (key_valid !== 1'b0 || key_code !== 4'd0) begin
            n_fail++;
            $display("FAIL bounce_early: got valid=%b code=%0d expected 0 0", key_valid, key_code);
        end
        adv(1);
        n_cmp++;
        if (key_valid !== 1'b1 || key_code !== 4'd9) begin
            n_fail++;
            $display("FAIL bounce_accept: got valid=%b code=%0d expected 1 9", key_valid, key_code);
        end
        adv(4);
        n_cmp++;
        if (valid_cnt - v0 !== 1) begin
            n_fail++;
            $display("FAIL bounce_single: got %0d pulses expected 1", valid_cnt - v0);
        end
    endtask

    // Rows 1 and 3 closed on column 3; row 1 wins, row 3 never reports.
    task automatic test_multi();
        int v0;
        mask = 16'h0000;
        mask[7] = 1'b1;
        mask[15] = 1'b1;
        do_reset();
        v0 = valid_cnt;
        adv(24);
        n_cmp++;
        if (key_valid !== 1'b1 || key_code !== 4'd7) begin
            n_fail++;
            $display("FAIL multi_accept: got valid=%b code=%0d expected 1 7", key_valid, key_code);
        end
        mask[7] = 1'b0;
        adv(20);
        n_cmp++;
        if (valid_cnt - v0 !== 1 || key_code !== 4'd7 || key_pressed !== 1'b1) begin
            n_fail++;
            $display("FAIL multi_ignore: got pulses=%0d code=%0d pressed=%b expected 1 7 1",
                     valid_cnt - v0, key_code, key_pressed);
        end
    endtask

    task automatic test_reset_mid();
        mask = 16'h0000;
        mask[9] = 1'b1;
        do_reset();
        adv(20);
        n_cmp++;
        if (key_pressed !== 1'b1) begin
            n_fail++;
            $display("FAIL midrst_pre: got pressed=%b expected 1", key_pressed);
        end
        reset = 1'b0;
        #1;
        n_cmp++;
        if (key_pressed !== 1'b0 || key_code !== 4'd0 || col_out !== 4'b1110 || key_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL midrst_async: got pressed=%b code=%0d col=%b valid=%b expected 0 0 1110 0",
                     key_pressed, key_code, col_out, key_valid);
        end
        do_reset();
        adv(15);
        n_cmp++;
        if (key_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL midrst_early: got valid=%b expected 0", key_valid);
        end
        adv(1);
        n_cmp++;
        if (key_valid !== 1'b1 || key_code !== 4'd9 || key_pressed !== 1'b1) begin
            n_fail++;
            $display("FAIL midrst_reaccept: got valid=%b code=%0d pressed=%b expected 1 9 1",
                     key_valid, key_code, key_pressed);
        end
    endtask

    initial begin
        n_cmp = 0;
        n_fail = 0;
        valid_cnt = 0;
        cyc = 0;
        mask = 16'h0000;
        reset = 1'b0;
        test_reset();
        test_hold_release();
        test_bounce();
        test_multi();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
